// File: rtl/stream_mux_rr.sv
// N-channel valid/ready stream multiplexer with a registered output stage.
// Channels are selected by round-robin arbitration or by a fixed index.
module stream_mux_rr #(
  parameter  int WIDTH = 8,
  parameter  int NCH   = 4,
  localparam int SELW  = $clog2(NCH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [NCH*WIDTH-1:0] in_data,
  input  logic [NCH-1:0]       in_valid,
  output logic [NCH-1:0]       in_ready,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SELW-1:0]      out_ch
);

  logic [SELW-1:0] rr_ptr;
  logic [SELW-1:0] rr_next;
  logic [NCH-1:0]  grant;
  logic [SELW-1:0] gnt_idx;
  logic            load_en;
  logic            xfer;

  // The output register can take a word when empty or when it drains this cycle.
  assign load_en = !out_valid || out_ready;

  // NOTE: every variable gets a default at the top of always_comb, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    logic found;
    int   c;
    grant   = '0;
    gnt_idx = '0;
    found   = 1'b0;
    c       = 0;
    if (mode) begin
      // An out-of-range sel matches no channel, so nothing is granted.
      for (int i = 0; i < NCH; i++) begin
        if (int'(sel) == i && in_valid[i]) begin
          grant[i] = 1'b1;
          gnt_idx  = SELW'(i);
        end
      end
    end else begin
      for (int k = 0; k < NCH; k++) begin
        c = (int'(rr_ptr) + k) % NCH;
        if (!found && in_valid[c]) begin
          grant[c] = 1'b1;
          gnt_idx  = SELW'(c);
          found    = 1'b1;
        end
      end
    end
  end

  assign xfer     = (|grant) && load_en;
  assign in_ready = rst_n ? (grant & {NCH{load_en}}) : '0;
  assign rr_next  = (int'(gnt_idx) == NCH - 1) ? '0 : gnt_idx + SELW'(1);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the values from before the edge, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      rr_ptr    <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= in_data[int'(gnt_idx)*WIDTH +: WIDTH];
      out_ch    <= gnt_idx;
      if (!mode) rr_ptr <= rr_next;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_stream_mux_rr.sv
// Self-checking bench for stream_mux_rr: directed scenarios followed by random
// traffic, all compared against a transaction-level reference model.
module tb_stream_mux_rr;

  localparam int WIDTH = 8;
  localparam int NCH   = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             mode;
  logic [1:0]       sel;
  logic [31:0]      in_data;
  logic [3:0]       in_valid;
  logic [3:0]       in_ready;
  logic [7:0]       out_data;
  logic             out_valid;
  logic             out_ready;
  logic [1:0]       out_ch;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model state: the word held at the output and the rotation pointer.
  bit       m_valid;
  bit [7:0] m_data;
  int       m_ch;
  int       m_ptr;

  stream_mux_rr #(.WIDTH(WIDTH), .NCH(NCH)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .mode      (mode),
    .sel       (sel),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_ch    (out_ch)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Winner of one arbitration round: fixed index, or first requester at or after ptr.
  function automatic int pick(input logic [3:0] v, input logic m, input int s, input int ptr);
    if (m) return (s < NCH && v[s]) ? s : -1;
    for (int off = 0; off < NCH; off++)
      if (v[(ptr + off) % NCH]) return (ptr + off) % NCH;
    return -1;
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = 8'h00;
    m_ch    = 0;
    m_ptr   = 0;
  endtask

  // Called just after a rising edge with inputs already driven; returns just
  // after the next rising edge with the model advanced and outputs compared.
  task automatic step(input string tag);
    int   g;
    bit   load;
    logic [3:0] er;
    #1;
    load = !m_valid || out_ready;
    g    = pick(in_valid, mode, int'(sel), m_ptr);
    er   = (g >= 0 && load) ? 4'(1 << g) : 4'b0000;
    check({tag, ".in_ready"}, 32'(in_ready), 32'(er));
    @(posedge clk);
    #1;
    if (g >= 0 && load) begin
      m_valid = 1'b1;
      m_data  = in_data[g*8 +: 8];
      m_ch    = g;
      if (!mode) m_ptr = (g + 1) % NCH;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    check({tag, ".out_valid"}, 32'(out_valid), 32'(m_valid));
    check({tag, ".out_data"},  32'(out_data),  32'(m_data));
    check({tag, ".out_ch"},    32'(out_ch),    32'(m_ch));
  endtask

  task automatic reset_dut();
    rst_n = 1'b0;
    #1;
    model_reset();
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n     = 1'b0;
    mode      = 1'b0;
    sel       = 2'd0;
    in_data   = {8'h44, 8'h33, 8'h22, 8'h11};
    in_valid  = 4'b1111;
    out_ready = 1'b1;
    model_reset();

    // 1. Reset held with all channels requesting.
    repeat (3) @(posedge clk);
    #1;
    check("rst.out_valid", 32'(out_valid), 32'd0);
    check("rst.out_data",  32'(out_data),  32'd0);
    check("rst.out_ch",    32'(out_ch),    32'd0);
    check("rst.in_ready",  32'(in_ready),  32'd0);
    rst_n = 1'b1;

    // 2. Round-robin with every channel valid.
    for (int k = 0; k < 8; k++) begin
      step("rr_all");
      check("rr_all.seq_data", 32'(out_data), 32'((k % 4 + 1) * 8'h11));
      check("rr_all.seq_ch",   32'(out_ch),   32'(k % 4));
    end

    // 3. Sparse requests: only channels 1 and 3.
    in_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      step("rr_sparse");
      check("rr_sparse.seq_ch", 32'(out_ch), (k % 2) ? 32'd3 : 32'd1);
    end

    // 4. Fixed select on channel 2, then channel 2 stops requesting.
    mode     = 1'b1;
    sel      = 2'd2;
    in_valid = 4'b1111;
    for (int k = 0; k < 4; k++) begin
      step("fixed");
      check("fixed.seq_data", 32'(out_data), 32'h33);
    end
    in_valid = 4'b1011;
    step("fixed_idle");
    check("fixed_idle.drop", 32'(out_valid), 32'd0);

    // 5. Backpressure right after the first word.
    reset_dut();
    mode      = 1'b0;
    in_valid  = 4'b1111;
    out_ready = 1'b0;
    step("bp_first");
    check("bp_first.data", 32'(out_data), 32'h11);
    for (int k = 0; k < 5; k++) begin
      step("bp_hold");
      check("bp_hold.data", 32'(out_data), 32'h11);
    end
    out_ready = 1'b1;
    step("bp_release");
    check("bp_release.data",  32'(out_data),  32'h22);
    check("bp_release.valid", 32'(out_valid), 32'd1);

    // 6. Asynchronous reset between edges while a word is held.
    step("mid_a");
    step("mid_b");
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst.out_valid", 32'(out_valid), 32'd0);
    check("mid_rst.in_ready",  32'(in_ready),  32'd0);
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("after_rst");
    check("after_rst.first_ch", 32'(out_ch), 32'd0);

    // 7. Random traffic across both modes with random backpressure.
    for (int k = 0; k < 600; k++) begin
      in_data   = $urandom;
      in_valid  = 4'($urandom_range(0, 15));
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 7) == 0) mode = ~mode;
      if ($urandom_range(0, 7) == 0) sel  = 2'($urandom_range(0, 3));
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/stream_mux_rr.md
Name: stream_mux_rr

Overview:
- Parametrised N-channel, WIDTH-bit multiplexer with valid/ready handshake on every input and on the output.
- Two selection modes: round-robin arbitration across requesting channels, or fixed channel select.
- Output is registered, so it sits directly between streaming datapath stages.
- Records which channel supplied each output word.

Parameters:
- WIDTH, 8, data width per channel in bits.
- NCH, 4, number of input channels (2..16).
- SELW, $clog2(NCH), width of the channel index; derived, never overridden.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  1  0 = round-robin, 1 = fixed select.
- sel  input  SELW  channel index used when mode=1.
- in_data  input  NCH*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NCH  per-channel valid.
- in_ready  output  NCH  per-channel ready, combinational.
- out_data  output  WIDTH  registered data.
- out_valid  output  1  registered valid.
- out_ready  input  1  downstream ready.
- out_ch  output  SELW  index of the channel that supplied out_data.

Behaviour:
- Reset (async assert, sync release): out_valid=0, out_data=0, out_ch=0, rr_ptr=0. in_ready is 0 while rst_n=0.
- load_en = !out_valid | out_ready. The output register accepts a new word whenever it is empty or is being drained in the same cycle.
- Grant is one-hot or zero; it is combinational from in_valid, mode, sel and rr_ptr.
  - mode=0: search channels rr_ptr, rr_ptr+1, ..., wrapping modulo NCH. The first one with in_valid=1 wins.
  - mode=1: grant[sel] = in_valid[sel]. If sel >= NCH, nothing is granted.
- in_ready[i] = grant[i] & load_en.
- A transfer on channel i occurs when in_valid[i] & in_ready[i].
- On a transfer at edge k:
  - out_data <= channel i data, out_ch <= i, out_valid <= 1 at edge k. Latency is one cycle.
  - In mode=0 only: rr_ptr <= (i+1) mod NCH. rr_ptr is unchanged in mode=1 and on cycles with no transfer.
- No transfer but out_ready=1 with out_valid=1: out_valid <= 0. out_data and out_ch hold their last values.
- Backpressure: while out_valid=1 and out_ready=0, out_data, out_valid and out_ch hold stable, and all in_ready are 0.
- Throughput: one word per cycle when out_ready is held at 1.
- Simultaneous drain and load: out_valid stays 1 and the new word replaces the old one, with no bubble.
- Fairness: in mode=0, with all channels continuously valid, output order is 0,1,...,NCH-1,0,...
  - Each requesting channel is granted within NCH transfers.
- Mode or sel changes take effect on the next grant evaluation. They never corrupt a word already held in the output register.
- Reset mid-operation: the held word is dropped immediately and the pointer returns to 0. Upstream must treat a word in flight as not accepted.
- sel containing X/Z in mode=1 is illegal. The bench must not drive it.

Test Plan:
1. Reset, WIDTH=8, NCH=4. Hold rst_n=0 with all in_valid=1 → out_valid=0, out_data=0, out_ch=0, in_ready=4'b0000.
2. Round-robin, mode=0:
   - Drive in_data = {8'h44,8'h33,8'h22,8'h11}, all valid, out_ready=1, for 8 cycles.
   - Expect out_data 11,22,33,44,11,22,33,44 on consecutive cycles, out_ch 0,1,2,3,0,1,2,3.
   - Expect in_ready one-hot rotating 0001,0010,0100,1000.
3. Sparse request, mode=0: in_valid=4'b1010, out_ready=1 → out_ch alternates 1,3,1,3 and channels 0 and 2 never get in_ready.
4. Fixed select, mode=1:
   - sel=2, all valid → every output is 8'h33 with out_ch=2.
   - sel=2 with in_valid[2]=0 → out_valid falls to 0 after one cycle.
5. Backpressure:
   - out_ready=0 for 5 cycles after first word 8'h11 → out_data=8'h11 stable, in_ready=0 throughout.
   - On out_ready=1, next word 8'h22 appears with no bubble and no lost or duplicated word.
6. Reset mid-stream: assert rst_n=0 asynchronously between edges while out_valid=1 → out_valid=0 immediately; after release the first grant goes to channel 0.
